// File: rtl/tms_kbd_pkg.sv
// Shared widths, event layout and debounce threshold for the keyboard-matrix front end.
// No logic here beyond a pure helper; no latency or flow control of its own.
package tms_kbd_pkg;

  localparam int EVT_W         = 7;
  localparam int CODE_W        = 6;
  localparam int EVT_PRESS_BIT = 6;
  localparam int DEB_THRESH    = 3;

  typedef struct packed {
    logic              press;
    logic [CODE_W-1:0] code;
  } evt_t;

  function automatic evt_t mk_evt(input logic press, input logic [CODE_W-1:0] code);
    evt_t e;
    e.press = press;
    e.code  = code;
    return e;
  endfunction

endpackage

// File: rtl/tms_kbd_evt_fifo.sv
// Generic synchronous FIFO; head visible the cycle after a push into an empty FIFO.
// Pushes while full and pops while empty are ignored; the producer must check full_o.
module tms_kbd_evt_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tms_key_matrix.sv
// Sync + debounce of a raw key matrix, K regeneration for the strobed R rows (1 cycle), and a
// press/release event stream; when the event FIFO is full the event is retried and evt_ovf sticks.
module tms_key_matrix
  import tms_kbd_pkg::*;
#(
  parameter int N_ROWS     = 16,
  parameter int TICK_DIV   = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [N_ROWS*4-1:0] key_raw,
  input  logic [N_ROWS-1:0]   R_in,
  output logic [3:0]          K_out,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [EVT_W-1:0]    evt_data,
  output logic                evt_ovf,
  input  logic                ovf_clr
);

  localparam int N_KEYS = N_ROWS * 4;
  localparam int TW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [N_KEYS-1:0]      key_meta_q;
  logic [N_KEYS-1:0]      key_s_q;
  logic [TW-1:0]          tick_cnt_q;
  logic [TW-1:0]          tick_cnt_d;
  logic                   tick;
  logic [N_KEYS-1:0]      deb_q;
  logic [N_KEYS-1:0][1:0] cnt_q;
  logic [N_KEYS-1:0]      rep_q;
  logic [CODE_W-1:0]      idx_q;
  logic [CODE_W-1:0]      idx_d;
  logic [3:0]             k_q;
  logic [3:0]             k_d;
  logic                   ovf_q;
  logic                   ovf_d;
  logic                   scan_diff;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  evt_t                   push_evt;

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      key_meta_q <= '0;
      key_s_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      key_meta_q <= key_raw;
      key_s_q    <= key_meta_q;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Each key needs DEB_THRESH consecutive differing samples; one agreeing sample restarts it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (key_s_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == 2'(DEB_THRESH - 1)) begin
          deb_q[i] <= key_s_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 2'd1;
        end
      end
    end
  end

  always_comb begin
    k_d = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (R_in[r]) k_d = k_d | deb_q[r*4 +: 4];
    end
  end

  // Fullness is the pre-pop value, so a same-cycle pop never lets a push through.
  assign scan_diff = (deb_q[idx_q] != rep_q[idx_q]);
  assign push      = scan_diff && !fifo_full;
  assign push_evt  = mk_evt(deb_q[idx_q], idx_q);
  assign idx_d     = (idx_q == CODE_W'(N_KEYS - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (scan_diff && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rep_q <= '0;
      idx_q <= '0;
      k_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) rep_q[idx_q] <= deb_q[idx_q];
      idx_q <= idx_d;
      k_q   <= k_d;
      ovf_q <= ovf_d;
    end
  end

  tms_kbd_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_ni),
    .push_i     (push),
    .push_dat_i (push_evt),
    .pop_i      (evt_valid && evt_ready),
    .head_dat_o (evt_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign K_out     = k_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_tms_key_matrix.sv
// Directed bench for tms_key_matrix with TICK_DIV=4; events are checked by a scoreboard monitor.
module tb_tms_key_matrix;

  logic        clk;
  logic        rst_n;
  logic [63:0] key_raw;
  logic [15:0] R_in;
  logic [3:0]  K_out;
  logic        evt_valid;
  logic        evt_ready;
  logic [6:0]  evt_data;
  logic        evt_ovf;
  logic        ovf_clr;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  tms_key_matrix #(
    .N_ROWS     (16),
    .TICK_DIV   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .key_raw   (key_raw),
    .R_in      (R_in),
    .K_out     (K_out),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Events for keys that change together leave in scan order, so match against any pending entry.
  always @(negedge clk) begin
    int hit;
    hit = -1;
    if (rst_n && evt_valid && evt_ready) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (hit < 0 && exp_q[i] == evt_data) hit = i;
      end
      checks++;
      if (hit < 0) begin
        errors++;
        $display("FAIL evt_data: got %h, not among %0d expected pending events", evt_data, exp_q.size());
      end else begin
        exp_q.delete(hit);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    step(80);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic press(input int code, input logic val);
    key_raw[code] = val;
    exp_q.push_back({val, 6'(code)});
  endtask

  initial begin
    rst_n     = 1'b0;
    key_raw   = '1;
    R_in      = '1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_k_out", 8'(K_out), 8'h0);
    chk("rst_evt_valid", 8'(evt_valid), 8'h0);
    chk("rst_evt_data", 8'(evt_data), 8'h0);
    chk("rst_evt_ovf", 8'(evt_ovf), 8'h0);

    // All keys held through reset: nothing until debounce completes, then 64 presses.
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) exp_q.push_back({1'b1, 6'(i)});
    step(5);
    @(negedge clk);
    chk("early_k_out", 8'(K_out), 8'h0);
    chk("early_evt_valid", 8'(evt_valid), 8'h0);
    wait_empty("all_press", 300);
    chk("all_k_out", 8'(K_out), 8'hF);

    for (int i = 0; i < 64; i++) exp_q.push_back({1'b0, 6'(i)});
    key_raw = '0;
    wait_empty("all_release", 300);
    chk("released_k_out", 8'(K_out), 8'h0);

    // Clean press of row 3 K1 and registered K regeneration.
    R_in = '0;
    step(2);
    press(13, 1'b1);
    wait_empty("press13", 300);
    R_in = 16'h0008;
    @(negedge clk);
    chk("k_before_edge", 8'(K_out), 8'h0);
    @(negedge clk);
    chk("k_row3", 8'(K_out), 8'h2);
    step(1);
    press(13, 1'b0);
    wait_empty("release13", 300);
    chk("k_row3_rel", 8'(K_out), 8'h0);

    // Bounce 1,0,1 one tick each, then hold: only one press, late flip.
    key_raw[13] = 1'b1;
    step(4);
    key_raw[13] = 1'b0;
    step(4);
    press(13, 1'b1);
    step(7);
    @(negedge clk);
    chk("bounce_no_flip", 8'(K_out), 8'h0);
    step(12);
    @(negedge clk);
    chk("bounce_flip", 8'(K_out), 8'h2);
    wait_empty("bounce_evt", 300);
    press(13, 1'b0);
    wait_empty("bounce_rel", 300);

    // Two strobed rows OR together; no strobe gives zero.
    press(0, 1'b1);
    press(13, 1'b1);
    wait_empty("two_keys", 300);
    R_in = 16'h0009;
    @(negedge clk);
    @(negedge clk);
    chk("k_rows_0_3", 8'(K_out), 8'h3);
    step(1);
    R_in = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("k_no_strobe", 8'(K_out), 8'h0);
    step(1);
    press(0, 1'b0);
    press(13, 1'b0);
    wait_empty("two_rel", 300);
    chk("ovf_idle", 8'(evt_ovf), 8'h0);

    // Six presses with the consumer stalled: four fit, two are deferred.
    evt_ready = 1'b0;
    press(2, 1'b1);  step(100);
    press(7, 1'b1);  step(100);
    press(20, 1'b1); step(100);
    press(33, 1'b1); step(100);
    @(negedge clk);
    chk("full_no_ovf", 8'(evt_ovf), 8'h0);
    step(1);
    press(45, 1'b1); step(100);
    press(63, 1'b1); step(100);
    @(negedge clk);
    chk("stall_valid", 8'(evt_valid), 8'h1);
    chk("stall_head", 8'(evt_data), 8'h42);
    chk("stall_ovf", 8'(evt_ovf), 8'h1);
    step(5);
    @(negedge clk);
    chk("stall_head_stable", 8'(evt_data), 8'h42);
    step(1);
    evt_ready = 1'b1;
    wait_empty("drain", 400);
    chk("ovf_sticky", 8'(evt_ovf), 8'h1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 8'(evt_ovf), 8'h0);
    step(1);

    // Three releases queued, then an asynchronous reset drops them.
    evt_ready = 1'b0;
    key_raw[2]  = 1'b0;
    key_raw[7]  = 1'b0;
    key_raw[20] = 1'b0;
    step(100);
    @(negedge clk);
    chk("queued_valid", 8'(evt_valid), 8'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 8'(evt_valid), 8'h0);
    chk("async_rst_data", 8'(evt_data), 8'h0);
    step(2);
    rst_n = 1'b1;
    exp_q.push_back(7'h61);
    exp_q.push_back(7'h6D);
    exp_q.push_back(7'h7F);
    evt_ready = 1'b1;
    wait_empty("re_press", 300);
    chk("post_rst_ovf", 8'(evt_ovf), 8'h0);

    press(33, 1'b0);
    press(45, 1'b0);
    press(63, 1'b0);
    wait_empty("final_rel", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
